mem_stage: RTL
==============

# mem_stage

Memory-access stage plus MEM/WB pipeline register of the RISC-V pipeline. It performs RV32I loads and stores against an internal byte-addressable data memory. It registers the load data, the ALU result, and the writeback controls into the WB stage, which then selects between DATA_MEMORY_WB and ALU_OUT_WB. It produces exactly the operands that the writeback multiplexer consumes.

## Interface
- DEPTH_WORDS, 256: data memory size in 32-bit words; must be a power of two.
- ADDR_W, 8: log2(DEPTH_WORDS).
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- STALL_MEM  in  1  hold the MEM/WB register and suppress the store.
- FLUSH_MEM  in  1  insert a bubble into WB.
- ALU_OUT_MEM  in  32  effective address or ALU result.
- WRITE_DATA_MEM  in  32  store data (rs2).
- MemRead_MEM, MemWrite_MEM, MemtoReg_MEM, RegWrite_MEM  in  1 each  control bits.
- FUNCT3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RD_MEM  in  5  destination register.
- DATA_MEMORY_WB  out  32  registered load result, already extended.
- ALU_OUT_WB  out  32  registered ALU result.
- MemtoReg_WB, RegWrite_WB  out  1 each  registered controls.
- RD_WB  out  5  registered destination register.
- MISALIGNED_WB  out  1  registered misaligned-access flag.

## Operation
- Word index is ALU_OUT_MEM[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS*4.
- Byte offset is ALU_OUT_MEM[1:0].
- Alignment rules:
  - H/HU require offset[0]=0.
  - W requires offset=00.
  - B/BU are always aligned.
  - Any FUNCT3 value not listed is treated as W.
- Stores write the byte lanes selected by FUNCT3 and offset, using the low bits of WRITE_DATA_MEM:
  - SB writes lane offset with WRITE_DATA_MEM[7:0].
  - SH writes lanes offset and offset+1 with WRITE_DATA_MEM[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Loads select the lane(s) the same way, then extend the result:
  - B and H sign-extend.
  - BU and HU zero-extend.
  - W passes the word through.
- Misaligned access (with MemRead_MEM or MemWrite_MEM set):
  - the store is suppressed;
  - load data is 0;
  - RegWrite is forced to 0 in WB;
  - MISALIGNED_WB=1 for one WB cycle.
- When MemRead_MEM=0, DATA_MEMORY_WB is 0.
- Data memory contents are not affected by reset and are initially undefined.

## Timing
- Memory read is a combinational array read. The result is captured into the MEM/WB register on the rising edge.
- Latency is one cycle: inputs present in cycle N appear on the WB outputs in cycle N+1.
- Stores commit on the rising edge that ends cycle N, qualified by MemWrite_MEM & aligned & ~STALL_MEM & ~FLUSH_MEM & ~reset.
- Store followed by load to the same word in cycle N+1: the load returns the new data.
- Reset:
  - all WB outputs go to 0, including RegWrite_WB=0 and MISALIGNED_WB=0;
  - a store presented in the reset cycle does not commit.
- STALL_MEM=1: all WB outputs hold their values and no store commits.
- FLUSH_MEM=1: the WB register loads a bubble (all outputs 0) and no store commits.
- STALL_MEM and FLUSH_MEM both 1: flush wins.
- Reset has priority over both flush and stall.

## Structure
- Shared package (risc_v_pkg) holds:
  - FUNCT3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the MEM/WB bundle field widths.
- One sub-module, data_memory:
  - byte-lane write enable, combinational 32-bit word read, DEPTH_WORDS parameter;
  - implemented as four byte-wide arrays.
- The top level holds:
  - lane/alignment decode;
  - load extension;
  - the MEM/WB register.
- No state machine: a single pipeline register plus storage.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW from 0x10 with MemtoReg=1, RD=5 -> next cycle DATA_MEMORY_WB=0xDEADBEEF, RD_WB=5, RegWrite_WB=1.
- After the above, LB from 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF; SH 0x1234 to 0x12, then LW 0x10 -> 0x123455EF.
- LW from 0x12 -> MISALIGNED_WB=1, RegWrite_WB=0, DATA_MEMORY_WB=0. SW 0xFFFFFFFF to 0x11 -> a following LW 0x10 is unchanged (0x123455EF).
- SW with STALL_MEM=1 or FLUSH_MEM=1 -> memory unchanged. Under stall, WB outputs hold the previous values; under flush, WB outputs are all 0.
- Reset asserted while a valid load is in WB and an SW to 0x20 is in MEM -> next cycle all WB outputs are 0 and a later LW 0x20 does not return the store data.
- Address wrap-around: with DEPTH_WORDS=256, SW 0xA5A5A5A5 to 0x400 -> LW 0x000 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/risc_v_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_pkg
// Description : Shared RV32I load/store encodings and the MEM/WB bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_v_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [XLEN-1:0]       alu;
    logic                  memtoreg;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] rd;
    logic                  misaligned;
  } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Word-addressed data RAM built from four byte-wide lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
  import risc_v_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we_i[i]) mem[addr_i] <= wdata_i[8*i +: 8];
    end

    assign rdata_o[8*i +: 8] = mem[addr_i];
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RV32I memory-access stage with the MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import risc_v_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  STALL_MEM,
  input  logic                  FLUSH_MEM,
  input  logic [XLEN-1:0]       ALU_OUT_MEM,
  input  logic [XLEN-1:0]       WRITE_DATA_MEM,
  input  logic                  MemRead_MEM,
  input  logic                  MemWrite_MEM,
  input  logic                  MemtoReg_MEM,
  input  logic                  RegWrite_MEM,
  input  logic [2:0]            FUNCT3_MEM,
  input  logic [REG_ADDR_W-1:0] RD_MEM,
  output logic [XLEN-1:0]       DATA_MEMORY_WB,
  output logic [XLEN-1:0]       ALU_OUT_WB,
  output logic                  MemtoReg_WB,
  output logic                  RegWrite_WB,
  output logic [REG_ADDR_W-1:0] RD_WB,
  output logic                  MISALIGNED_WB
);

  logic [1:0]      offset;
  logic            is_byte, is_half, misaligned;
  logic [3:0]      lane_sel, we;
  logic [XLEN-1:0] wdata, rword, rshift, load_val;
  logic            w_unused_addr;
  mem_wb_t         wb_d, wb_q;

  assign offset        = ALU_OUT_MEM[1:0];
  assign w_unused_addr = ^ALU_OUT_MEM[XLEN-1:ADDR_W+2];

  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    lane_sel = 4'b1111;
    wdata    = WRITE_DATA_MEM;
    case (FUNCT3_MEM)
      F3_B, F3_BU: begin
        is_byte  = 1'b1;
        lane_sel = 4'b0001 << offset;
        wdata    = {4{WRITE_DATA_MEM[7:0]}};
      end
      F3_H, F3_HU: begin
        is_half  = 1'b1;
        lane_sel = offset[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{WRITE_DATA_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  // Unlisted FUNCT3 codes fall through to word size, so they need offset 00.
  assign misaligned = (MemRead_MEM | MemWrite_MEM) &
                      (is_byte ? 1'b0 : (is_half ? offset[0] : (offset != 2'b00)));

  assign we = (MemWrite_MEM & ~misaligned & ~STALL_MEM & ~FLUSH_MEM & ~reset)
              ? lane_sel : 4'b0000;

  data_memory #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_data_memory (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (ALU_OUT_MEM[ADDR_W+1:2]),
    .wdata_i (wdata),
    .rdata_o (rword)
  );

  assign rshift = rword >> {offset, 3'b000};

  always_comb begin
    load_val = rword;
    case (FUNCT3_MEM)
      F3_B:    load_val = {{24{rshift[7]}}, rshift[7:0]};
      F3_BU:   load_val = {24'h0, rshift[7:0]};
      F3_H:    load_val = {{16{rshift[15]}}, rshift[15:0]};
      F3_HU:   load_val = {16'h0, rshift[15:0]};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    wb_d            = '0;
    wb_d.data       = (MemRead_MEM & ~misaligned) ? load_val : '0;
    wb_d.alu        = ALU_OUT_MEM;
    wb_d.memtoreg   = MemtoReg_MEM;
    wb_d.regwrite   = RegWrite_MEM & ~misaligned;
    wb_d.rd         = RD_MEM;
    wb_d.misaligned = misaligned;
  end

  // Priority: reset, then flush (bubble), then stall (hold).
  always_ff @(posedge clk) begin
    if (reset || FLUSH_MEM) wb_q <= '0;
    else if (!STALL_MEM)    wb_q <= wb_d;
  end

  assign DATA_MEMORY_WB = wb_q.data;
  assign ALU_OUT_WB     = wb_q.alu;
  assign MemtoReg_WB    = wb_q.memtoreg;
  assign RegWrite_WB    = wb_q.regwrite;
  assign RD_WB          = wb_q.rd;
  assign MISALIGNED_WB  = wb_q.misaligned;

endmodule
`default_nettype wire
